// File: rtl/pcs_align_pkg.sv
// Shared definitions for the 40GBASE-R receive alignment controller.
// Holds the one-hot FSM encoding, per-state bit positions and the
// default lane count used by the controller and its map checker.
package pcs_align_pkg;

  localparam int unsigned LANE_N_DEF = 4;

  // Bit position of each state inside the one-hot state vector.
  localparam int unsigned ST_RESYNC_IDX    = 0;
  localparam int unsigned ST_WAIT_LOCK_IDX = 1;
  localparam int unsigned ST_CHECK_MAP_IDX = 2;
  localparam int unsigned ST_DESKEW_IDX    = 3;
  localparam int unsigned ST_ALIGNED_IDX   = 4;

  typedef enum logic [4:0] {
    ST_RESYNC    = 5'b00001,
    ST_WAIT_LOCK = 5'b00010,
    ST_CHECK_MAP = 5'b00100,
    ST_DESKEW    = 5'b01000,
    ST_ALIGNED   = 5'b10000
  } align_fsm_e;

endpackage

// File: rtl/lane_map_check.sv
// Combinational check of the physical-to-logical lane mapping.
// lane_map_i : per physical lane p, bits [p*LANE_N +: LANE_N] hold the
//              one-hot logical lane detected on p.
// map_v      : every row is one-hot and every logical lane is covered,
//              i.e. the map is a permutation.
// dup_v      : some logical lane is claimed by more than one physical
//              lane (debug visibility only).
module lane_map_check
  import pcs_align_pkg::*;
#(
  parameter int unsigned LANE_N = LANE_N_DEF
) (
  input  logic [LANE_N*LANE_N-1:0] lane_map_i,
  output logic                     map_v,
  output logic                     dup_v
);

  logic [LANE_N-1:0] row;
  logic [LANE_N-1:0] seen;
  logic              rows_ok;

  always_comb begin
    row     = '0;
    seen    = '0;
    rows_ok = 1'b1;
    dup_v   = 1'b0;
    for (int unsigned p = 0; p < LANE_N; p++) begin
      row = lane_map_i[p*LANE_N +: LANE_N];
      if (!$onehot(row)) begin
        rows_ok = 1'b0;
      end
      if ((seen & row) != '0) begin
        dup_v = 1'b1;
      end
      seen = seen | row;
    end
    map_v = rows_ok && (&seen);
  end

endmodule

// File: rtl/pcs_align_ctrl.sv
// Multi-lane PCS receive alignment controller (4-lane 40GBASE-R).
// Waits for AM lock on all lanes, validates the lane permutation, runs
// the deskew stage and reports link alignment.
// Ports:
//   clk, nreset      : clock, asynchronous active-low reset
//   signal_v_i       : SerDes signal valid; low forces RESYNC
//   valid_i          : gearbox valid; FSM and counters advance only when high
//   lane_lock_v_i    : per physical lane AM lock
//   lane_map_i       : per physical lane one-hot logical lane id
//   deskew_done_i    : deskew reports all lanes aligned (level)
//   deskew_err_i     : deskew FIFO over/underflow (level)
//   deskew_rst_o     : holds deskew in reset (level)
//   deskew_start_o   : one-cycle pulse on the first DESKEW cycle
//   align_status_o   : link aligned
//   lane_map_err_o   : result of the last map check, sticky until next check
//   loss_cnt_o       : saturating count of exits from ALIGNED
module pcs_align_ctrl
  import pcs_align_pkg::*;
#(
  parameter int unsigned LANE_N      = LANE_N_DEF,
  parameter int unsigned DESKEW_TO_N = 64,
  parameter int unsigned LOSS_CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     signal_v_i,
  input  logic                     valid_i,
  input  logic [LANE_N-1:0]        lane_lock_v_i,
  input  logic [LANE_N*LANE_N-1:0] lane_map_i,
  input  logic                     deskew_done_i,
  input  logic                     deskew_err_i,
  output logic                     deskew_rst_o,
  output logic                     deskew_start_o,
  output logic                     align_status_o,
  output logic                     lane_map_err_o,
  output logic [LOSS_CNT_W-1:0]    loss_cnt_o
);

  localparam int unsigned TO_W = (DESKEW_TO_N > 1) ? $clog2(DESKEW_TO_N) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DESKEW_TO_N - 1);

  align_fsm_e      state_q;
  align_fsm_e      state_d;
  logic [TO_W-1:0] to_cnt_q;
  logic            lock_all;
  logic            to_hit;
  logic            map_v;
  logic            dup_v;
  logic            map_err_d;

  assign lock_all = &lane_lock_v_i;
  assign to_hit   = (to_cnt_q == TO_LAST);

  lane_map_check #(
    .LANE_N(LANE_N)
  ) u_map_check (
    .lane_map_i(lane_map_i),
    .map_v     (map_v),
    .dup_v     (dup_v)
  );

  // Next-state logic. Event priority: signal loss, lock loss, deskew
  // error, timeout, done. Only signal loss acts without valid_i.
  always_comb begin
    state_d   = state_q;
    map_err_d = lane_map_err_o;
    if (!signal_v_i) begin
      state_d = ST_RESYNC;
    end else if (valid_i) begin
      unique case (state_q)
        ST_RESYNC: begin
          state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_all) state_d = ST_CHECK_MAP;
        end
        ST_CHECK_MAP: begin
          if (!lock_all) begin
            state_d = ST_WAIT_LOCK;
          end else if (map_v) begin
            state_d   = ST_DESKEW;
            map_err_d = 1'b0;
          end else begin
            state_d   = ST_RESYNC;
            map_err_d = 1'b1;
          end
        end
        ST_DESKEW: begin
          if (!lock_all)          state_d = ST_WAIT_LOCK;
          else if (deskew_err_i)  state_d = ST_RESYNC;
          else if (to_hit)        state_d = ST_RESYNC;
          else if (deskew_done_i) state_d = ST_ALIGNED;
        end
        ST_ALIGNED: begin
          if (!lock_all)                          state_d = ST_WAIT_LOCK;
          else if (deskew_err_i || !deskew_done_i) state_d = ST_RESYNC;
        end
        default: begin
          state_d = ST_RESYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_RESYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are registered from the next state so they line up with
  // the state register rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      to_cnt_q       <= '0;
      deskew_rst_o   <= 1'b1;
      deskew_start_o <= 1'b0;
      align_status_o <= 1'b0;
      lane_map_err_o <= 1'b0;
      loss_cnt_o     <= '0;
    end else begin
      if (state_q != ST_DESKEW) begin
        to_cnt_q <= '0;
      end else if (valid_i) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      deskew_rst_o   <= !((state_d == ST_DESKEW) || (state_d == ST_ALIGNED));
      deskew_start_o <= (state_q == ST_CHECK_MAP) && (state_d == ST_DESKEW);
      align_status_o <= (state_d == ST_ALIGNED);
      lane_map_err_o <= map_err_d;
      if ((state_q == ST_ALIGNED) && (state_d != ST_ALIGNED) && (loss_cnt_o != '1)) begin
        loss_cnt_o <= loss_cnt_o + LOSS_CNT_W'(1);
      end
    end
  end

  a_fsm_onehot : assert property (@(posedge clk) disable iff (!nreset)
    $onehot(state_q));

  // ALIGNED is only held without re-checking lock while valid_i is low.
  a_align_lock : assert property (@(posedge clk) disable iff (!nreset)
    (align_status_o && $past(valid_i)) |-> $past(lock_all));

  a_start_pulse : assert property (@(posedge clk) disable iff (!nreset)
    deskew_start_o |=> !deskew_start_o);

  a_dup_invalid : assert property (@(posedge clk) disable iff (!nreset)
    dup_v |-> !map_v);

endmodule

// File: tb/tb_pcs_align_ctrl.sv
module tb_pcs_align_ctrl;

  logic        clk = 1'b0;
  logic        nreset;
  logic        signal_v_i;
  logic        valid_i;
  logic [3:0]  lane_lock_v_i;
  logic [15:0] lane_map_i;
  logic        deskew_done_i;
  logic        deskew_err_i;
  logic        deskew_rst_o;
  logic        deskew_start_o;
  logic        align_status_o;
  logic        lane_map_err_o;
  logic [7:0]  loss_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcs_align_ctrl #(
    .LANE_N     (4),
    .DESKEW_TO_N(64),
    .LOSS_CNT_W (8)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .signal_v_i    (signal_v_i),
    .valid_i       (valid_i),
    .lane_lock_v_i (lane_lock_v_i),
    .lane_map_i    (lane_map_i),
    .deskew_done_i (deskew_done_i),
    .deskew_err_i  (deskew_err_i),
    .deskew_rst_o  (deskew_rst_o),
    .deskew_start_o(deskew_start_o),
    .align_status_o(align_status_o),
    .lane_map_err_o(lane_map_err_o),
    .loss_cnt_o    (loss_cnt_o)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with signal and valid high, locks all set, identity map.
  task automatic do_reset();
    nreset        = 1'b0;
    signal_v_i    = 1'b1;
    valid_i       = 1'b1;
    lane_lock_v_i = 4'hF;
    lane_map_i    = 16'h8421;
    deskew_done_i = 1'b0;
    deskew_err_i  = 1'b0;
    #2;
    nreset = 1'b1;
  endtask

  // From reset: RESYNC -> WAIT_LOCK -> CHECK_MAP -> DESKEW, then done -> ALIGNED.
  task automatic reach_aligned();
    do_reset();
    tick(3);
    deskew_done_i = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    nreset        = 1'b0;
    signal_v_i    = 1'b0;
    valid_i       = 1'b0;
    lane_lock_v_i = 4'h0;
    lane_map_i    = 16'h0;
    deskew_done_i = 1'b0;
    deskew_err_i  = 1'b0;
    #22;
    checks++; if (deskew_rst_o !== 1'b1) begin errors++; $display("FAIL reset_deskew_rst: got %b expected 1", deskew_rst_o); end
    checks++; if (deskew_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", deskew_start_o); end
    checks++; if (align_status_o !== 1'b0) begin errors++; $display("FAIL reset_align: got %b expected 0", align_status_o); end
    checks++; if (lane_map_err_o !== 1'b0) begin errors++; $display("FAIL reset_map_err: got %b expected 0", lane_map_err_o); end
    checks++; if (loss_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_loss_cnt: got %0d expected 0", loss_cnt_o); end
  endtask

  task automatic test_lock_map();
    nreset        = 1'b1;
    signal_v_i    = 1'b1;
    valid_i       = 1'b1;
    tick(3);
    lane_lock_v_i = 4'hF;
    lane_map_i    = 16'h8421;
    tick(1);
    checks++; if (deskew_start_o !== 1'b0) begin errors++; $display("FAIL lock_start_early: got %b expected 0", deskew_start_o); end
    tick(1);
    checks++; if (deskew_start_o !== 1'b1) begin errors++; $display("FAIL lock_start_pulse: got %b expected 1", deskew_start_o); end
    checks++; if (deskew_rst_o !== 1'b0) begin errors++; $display("FAIL lock_deskew_rst: got %b expected 0", deskew_rst_o); end
    deskew_done_i = 1'b1;
    checks++; if (align_status_o !== 1'b0) begin errors++; $display("FAIL lock_align_early: got %b expected 0", align_status_o); end
    tick(1);
    checks++; if (deskew_start_o !== 1'b0) begin errors++; $display("FAIL lock_start_width: got %b expected 0", deskew_start_o); end
    checks++; if (align_status_o !== 1'b1) begin errors++; $display("FAIL lock_align: got %b expected 1", align_status_o); end
  endtask

  task automatic test_swap_map();
    do_reset();
    lane_map_i = 16'h1248;
    tick(3);
    checks++; if (deskew_start_o !== 1'b1) begin errors++; $display("FAIL swap_start: got %b expected 1", deskew_start_o); end
    checks++; if (lane_map_err_o !== 1'b0) begin errors++; $display("FAIL swap_map_err: got %b expected 0", lane_map_err_o); end
  endtask

  task automatic test_dup_map();
    do_reset();
    lane_map_i = 16'h1148;
    tick(3);
    checks++; if (lane_map_err_o !== 1'b1) begin errors++; $display("FAIL dup_map_err: got %b expected 1", lane_map_err_o); end
    checks++; if (deskew_start_o !== 1'b0) begin errors++; $display("FAIL dup_start: got %b expected 0", deskew_start_o); end
    checks++; if (deskew_rst_o !== 1'b1) begin errors++; $display("FAIL dup_deskew_rst: got %b expected 1", deskew_rst_o); end
    lane_map_i = 16'h8421;
    tick(2);
    checks++; if (lane_map_err_o !== 1'b1) begin errors++; $display("FAIL dup_sticky: got %b expected 1", lane_map_err_o); end
    tick(1);
    checks++; if (lane_map_err_o !== 1'b0) begin errors++; $display("FAIL dup_cleared: got %b expected 0", lane_map_err_o); end
    checks++; if (deskew_start_o !== 1'b1) begin errors++; $display("FAIL dup_recover_start: got %b expected 1", deskew_start_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    tick(3);
    tick(63);
    checks++; if (deskew_rst_o !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", deskew_rst_o); end
    tick(1);
    checks++; if (deskew_rst_o !== 1'b1) begin errors++; $display("FAIL timeout_fire: got %b expected 1", deskew_rst_o); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(3);
    tick(30);
    valid_i = 1'b0;
    tick(10);
    checks++; if (deskew_rst_o !== 1'b0) begin errors++; $display("FAIL stall_hold: got %b expected 0", deskew_rst_o); end
    valid_i = 1'b1;
    tick(33);
    checks++; if (deskew_rst_o !== 1'b0) begin errors++; $display("FAIL stall_timeout_early: got %b expected 0", deskew_rst_o); end
    tick(1);
    checks++; if (deskew_rst_o !== 1'b1) begin errors++; $display("FAIL stall_timeout_fire: got %b expected 1", deskew_rst_o); end
  endtask

  task automatic test_loss_aligned();
    int exp_cnt;
    reach_aligned();
    checks++; if (align_status_o !== 1'b1) begin errors++; $display("FAIL loss_setup_align: got %b expected 1", align_status_o); end
    for (int i = 1; i <= 300; i++) begin
      lane_lock_v_i = 4'hB;
      tick(1);
      exp_cnt = (i > 255) ? 255 : i;
      checks++; if (loss_cnt_o !== 8'(exp_cnt)) begin errors++; $display("FAIL loss_cnt iter %0d: got %0d expected %0d", i, loss_cnt_o, exp_cnt); end
      if (i == 1) begin
        checks++; if (align_status_o !== 1'b0) begin errors++; $display("FAIL loss_align_drop: got %b expected 0", align_status_o); end
        checks++; if (deskew_rst_o !== 1'b1) begin errors++; $display("FAIL loss_deskew_rst: got %b expected 1", deskew_rst_o); end
      end
      lane_lock_v_i = 4'hF;
      tick(1);
      if (i == 1) begin
        checks++; if (deskew_start_o !== 1'b0) begin errors++; $display("FAIL loss_wait_lock_start: got %b expected 0", deskew_start_o); end
      end
      tick(1);
      if (i == 1) begin
        checks++; if (deskew_start_o !== 1'b1) begin errors++; $display("FAIL loss_wait_lock_path: got %b expected 1", deskew_start_o); end
      end
      tick(1);
    end
    checks++; if (align_status_o !== 1'b1) begin errors++; $display("FAIL loss_realign: got %b expected 1", align_status_o); end
  endtask

  task automatic test_overrides();
    // Signal loss with valid low in DESKEW.
    do_reset();
    tick(3);
    valid_i    = 1'b0;
    signal_v_i = 1'b0;
    tick(1);
    checks++; if (deskew_rst_o !== 1'b1) begin errors++; $display("FAIL ovr_signal_deskew: got %b expected 1", deskew_rst_o); end
    // Signal loss in ALIGNED counts as an exit.
    reach_aligned();
    signal_v_i = 1'b0;
    tick(1);
    checks++; if (align_status_o !== 1'b0) begin errors++; $display("FAIL ovr_signal_align: got %b expected 0", align_status_o); end
    checks++; if (loss_cnt_o !== 8'd1) begin errors++; $display("FAIL ovr_signal_loss: got %0d expected 1", loss_cnt_o); end
    // Deskew error in DESKEW.
    do_reset();
    tick(3);
    deskew_err_i = 1'b1;
    tick(1);
    checks++; if (deskew_rst_o !== 1'b1) begin errors++; $display("FAIL ovr_deskew_err: got %b expected 1", deskew_rst_o); end
    // Done deassertion in ALIGNED.
    reach_aligned();
    deskew_done_i = 1'b0;
    tick(1);
    checks++; if (align_status_o !== 1'b0) begin errors++; $display("FAIL ovr_done_drop: got %b expected 0", align_status_o); end
    checks++; if (loss_cnt_o !== 8'd1) begin errors++; $display("FAIL ovr_done_loss: got %0d expected 1", loss_cnt_o); end
    // Asynchronous reset while ALIGNED with a non-zero loss count.
    reach_aligned();
    lane_lock_v_i = 4'h7;
    tick(1);
    lane_lock_v_i = 4'hF;
    tick(3);
    checks++; if (align_status_o !== 1'b1) begin errors++; $display("FAIL ovr_rst_setup: got %b expected 1", align_status_o); end
    #3;
    nreset = 1'b0;
    #1;
    checks++; if (align_status_o !== 1'b0) begin errors++; $display("FAIL ovr_rst_align: got %b expected 0", align_status_o); end
    checks++; if (loss_cnt_o !== 8'd0) begin errors++; $display("FAIL ovr_rst_loss: got %0d expected 0", loss_cnt_o); end
    checks++; if (deskew_rst_o !== 1'b1) begin errors++; $display("FAIL ovr_rst_deskew_rst: got %b expected 1", deskew_rst_o); end
    nreset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_map();
    test_swap_map();
    test_dup_map();
    test_timeout();
    test_stall();
    test_loss_aligned();
    test_overrides();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pcs_align_ctrl.md
# pcs_align_ctrl

Multi-lane PCS receive alignment controller for the 4-lane 40GBASE-R path. It collects per-lane alignment-marker lock and lane identity from the lane lock blocks, checks that the physical-to-logical lane mapping is a valid permutation, and sequences the deskew stage. It drives the link-level `align_status_o` consumed by the descrambler and the MAC-side status logic.

## Interface
Parameters:
- `LANE_N`, 4: number of PCS lanes.
- `DESKEW_TO_N`, 64: valid cycles allowed in DESKEW before timeout.
- `LOSS_CNT_W`, 8: width of the alignment-loss counter.

Ports:
- `clk` in 1: clock.
- `nreset` in 1: reset, asynchronous assert, active-low.
- `signal_v_i` in 1: SerDes signal valid. When low, the block is forced to RESYNC.
- `valid_i` in 1: gearbox valid. FSM and counters advance only when high.
- `lane_lock_v_i` in LANE_N: per physical lane, AM lock reached.
- `lane_map_i` in LANE_N*LANE_N: per physical lane p, bits [p*LANE_N +: LANE_N] give the one-hot logical lane detected on p.
- `deskew_done_i` in 1: deskew reports all lanes aligned. Level.
- `deskew_err_i` in 1: deskew FIFO over/underflow. Level.
- `deskew_rst_o` out 1: holds deskew in reset. Level.
- `deskew_start_o` out 1: single-cycle pulse that starts deskew.
- `align_status_o` out 1: link aligned.
- `lane_map_err_o` out 1: last map check failed. Sticky until the next check.
- `loss_cnt_o` out LOSS_CNT_W: saturating count of ALIGNED exits.

## Operation
- FSM, one-hot, states RESYNC, WAIT_LOCK, CHECK_MAP, DESKEW, ALIGNED.
- `signal_v_i` low overrides everything. Next state is RESYNC, evaluated every cycle regardless of `valid_i`.
- RESYNC:
  - `deskew_rst_o`=1, timeout cleared.
  - On `valid_i` with `signal_v_i` high, go to WAIT_LOCK.
- WAIT_LOCK:
  - `deskew_rst_o`=1.
  - When `&lane_lock_v_i` and `valid_i`, go to CHECK_MAP.
- CHECK_MAP (one valid cycle):
  - Map is valid iff every row is `$onehot` and the OR of all rows is all-ones.
  - Valid map: clear `lane_map_err_o`, pulse `deskew_start_o`, go to DESKEW.
  - Invalid map: set `lane_map_err_o`, go to RESYNC.
  - Any lane lock lost in this cycle: go to WAIT_LOCK. This has priority over the map result.
- DESKEW:
  - `deskew_rst_o`=0. The timeout counter increments on each `valid_i`.
  - `deskew_done_i`: go to ALIGNED.
  - Any of the following, in priority order after lock loss, sends the FSM to RESYNC: `deskew_err_i`, or the counter reaching DESKEW_TO_N-1 on a valid cycle.
  - Lane lock lost: go to WAIT_LOCK.
- ALIGNED:
  - `align_status_o`=1.
  - Any lock loss, `deskew_err_i`, or `deskew_done_i` deassertion exits. Lock loss goes to WAIT_LOCK; the others go to RESYNC.
  - Every exit, including exits forced by `signal_v_i`, increments `loss_cnt_o`. The counter saturates at all-ones and never wraps.
- Simultaneous events: `signal_v_i` low takes priority, then lock loss, then deskew error, then timeout, then done.
- Timeout counter width is `$clog2(DESKEW_TO_N)`. It is cleared on DESKEW entry.

## Timing
- All outputs are registered.
- Reset values:
  - State: RESYNC.
  - `deskew_rst_o`=1.
  - `deskew_start_o`=0.
  - `align_status_o`=0.
  - `lane_map_err_o`=0.
  - `loss_cnt_o`=0.
- `deskew_start_o` is high for exactly the first cycle in DESKEW: the cycle after the CHECK_MAP decision.
- `align_status_o` rises 1 cycle after a valid-qualified `deskew_done_i` in DESKEW. It falls 1 cycle after the exit condition.
- Minimum latency from all lanes locked to `deskew_start_o` is 2 valid cycles (WAIT_LOCK, then CHECK_MAP).
- With `valid_i` low, state and counters hold. The only exception is the `signal_v_i` override.
- `nreset` asserted mid-operation clears immediately (asynchronous), whatever the state.

## Structure
- Shared package `pcs_align_pkg` contains:
  - State enum `align_fsm_e` (5 one-hot states) and state index constants.
  - Default LANE_N.
- Sub-module `lane_map_check`: purely combinational. Inputs `lane_map_i`. Outputs `map_v` and `dup_v` (for debug).
- Formal assertions:
  - FSM is one-hot.
  - `align_status_o` implies `&lane_lock_v_i` on the previous cycle.
  - `deskew_start_o` is never high on two consecutive cycles.

## Test plan
- Lock and map path: reset; `signal_v_i`=1, `valid_i`=1; after 3 cycles set `lane_lock_v_i`=4'hF with identity map 16'h8421 -> `deskew_start_o` pulses 2 cycles later. Then `deskew_done_i`=1 -> `align_status_o`=1 the next cycle.
- Swapped but valid map: map 16'h1248 -> accepted, `lane_map_err_o`=0.
- Duplicate map: map 16'h1148 -> RESYNC, `lane_map_err_o`=1, no `deskew_start_o`.
- Deskew timeout: with DESKEW_TO_N=64, never assert `deskew_done_i` -> RESYNC after exactly 64 valid cycles, `deskew_rst_o` back to 1.
- Loss while aligned: drop lane 2 lock while ALIGNED -> `align_status_o`=0 next cycle, state WAIT_LOCK, `loss_cnt_o` 0->1. Repeat 300 times -> `loss_cnt_o` saturates at 255.
- Overrides and stalls:
  - `signal_v_i` low in DESKEW with `valid_i`=0 -> RESYNC next cycle.
  - `valid_i` low for 10 cycles mid-DESKEW -> timeout counter holds.
  - `nreset` pulse in ALIGNED -> all outputs return to reset values asynchronously.
